// File: rtl/ctmm_pkg.sv
// Shared types for the Church-Instruction front end: fault causes, the
// SWITCH/CHANGE opcodes, the decoded instruction layout and queue entries.
package ctmm_pkg;

    typedef enum logic [3:0] {
        FAULT_NONE    = 4'd0,
        FAULT_PERM    = 4'd1,
        FAULT_BOUNDS  = 4'd2,
        FAULT_TYPE    = 4'd3,
        FAULT_ILLEGAL = 4'd4,
        FAULT_TIMEOUT = 4'd5
    } fault_type_t;

    localparam logic [4:0] OPC_SWITCH = 5'h0C;
    localparam logic [4:0] OPC_CHANGE = 5'h0D;

    // Bit layout of a 32-bit Church instruction word, MSB first.
    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  cr_src;
        logic [2:0]  target;
        logic [9:0]  index;
        logic [10:0] rsvd;
    } church_inst_t;

    typedef struct packed {
        logic [31:0] word;
        logic [63:0] pc;
    } queue_entry_t;

    // A word is issuable only if it is SWITCH or CHANGE with clean reserved bits.
    function automatic logic is_legal(church_inst_t inst);
        return ((inst.opcode == OPC_SWITCH) || (inst.opcode == OPC_CHANGE)) &&
               (inst.rsvd == '0);
    endfunction

endpackage

// File: rtl/ctmm_inst_queue.sv
// Two-entry synchronous FIFO between fetch and the dispatch FSM.
// Flush empties it in the same cycle and wins over a simultaneous push or pop.
module ctmm_inst_queue
    import ctmm_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  queue_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output queue_entry_t head_data,
    output logic         full,
    output logic         empty
);

    queue_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    assign full      = (count == 2'd2);
    assign empty     = (count == 2'd0);
    assign head_data = mem[rd_ptr];
    assign do_push   = push && !full && !flush;
    assign do_pop    = pop && !empty && !flush;

    // Entry storage: written on push only.
    // NOTE: the data array is deliberately not reset; count and pointers guard every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; 1-bit pointers wrap from 1 to 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ctmm_church_dispatch.sv
// Issue stage for SWITCH/CHANGE: queues fetched words, decodes them, starts
// the SWITCH unit one operation at a time and reports exactly one retire or
// fault per operation. TIMEOUT_CYCLES must be in 2..65536.
module ctmm_church_dispatch
    import ctmm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst_word,
    input  logic [63:0] inst_pc,
    input  logic        flush,
    output logic        switch_start,
    output logic [2:0]  sw_cr_src,
    output logic [2:0]  sw_target,
    output logic [9:0]  sw_index,
    input  logic        switch_busy,
    input  logic        switch_complete,
    input  logic        switch_fault,
    input  fault_type_t sw_fault_type,
    output logic        retire_valid,
    output logic [63:0] retire_pc,
    output logic        fault_valid,
    output fault_type_t fault_cause,
    output logic [63:0] fault_pc,
    output logic        dispatch_idle
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t       state;
    logic         squash;
    logic [15:0]  tmo_cnt;
    logic [63:0]  op_pc;
    queue_entry_t head;
    church_inst_t head_inst;
    logic         q_full;
    logic         q_empty;
    logic         q_pop;
    logic         suppress;

    // The FSM consumes the head only while idle, and never during a flush.
    assign q_pop         = (state == S_IDLE) && !q_empty && !flush;
    assign inst_ready    = !q_full;
    assign head_inst     = church_inst_t'(head.word);
    assign dispatch_idle = (state == S_IDLE) && q_empty;
    // A flush in the terminating cycle squashes that report as well.
    assign suppress      = squash || flush;

    ctmm_inst_queue u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inst_valid),
        .push_data ('{word: inst_word, pc: inst_pc}),
        .pop       (q_pop),
        .flush     (flush),
        .head_data (head),
        .full      (q_full),
        .empty     (q_empty)
    );

    // Dispatch FSM with registered operand, start and report outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            squash       <= 1'b0;
            tmo_cnt      <= '0;
            op_pc        <= '0;
            switch_start <= 1'b0;
            sw_cr_src    <= '0;
            sw_target    <= '0;
            sw_index     <= '0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            fault_valid  <= 1'b0;
            fault_cause  <= FAULT_NONE;
            fault_pc     <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle so each is asserted for exactly one.
            switch_start <= 1'b0;
            retire_valid <= 1'b0;
            fault_valid  <= 1'b0;

            case (state)
                S_IDLE: begin
                    squash <= 1'b0;
                    if (q_pop) begin
                        op_pc <= head.pc;
                        if (!is_legal(head_inst)) begin
                            fault_valid <= 1'b1;
                            fault_cause <= FAULT_ILLEGAL;
                            fault_pc    <= head.pc;
                        end else begin
                            sw_cr_src <= head_inst.cr_src;
                            sw_target <= (head_inst.opcode == OPC_CHANGE) ? 3'd0
                                                                          : head_inst.target;
                            sw_index  <= head_inst.index;
                            state     <= S_ISSUE;
                        end
                    end
                end

                S_ISSUE: begin
                    if (flush) begin
                        squash <= 1'b1;
                    end
                    // Never start the unit while it is still busy with a previous op.
                    if (!switch_busy) begin
                        switch_start <= 1'b1;
                        tmo_cnt      <= '0;
                        state        <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (switch_fault) begin
                        if (!suppress) begin
                            fault_valid <= 1'b1;
                            fault_cause <= sw_fault_type;
                            fault_pc    <= op_pc;
                        end
                        squash <= 1'b0;
                        state  <= S_IDLE;
                    end else if (switch_complete) begin
                        if (!suppress) begin
                            retire_valid <= 1'b1;
                            retire_pc    <= op_pc;
                        end
                        squash <= 1'b0;
                        state  <= S_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        if (!suppress) begin
                            fault_valid <= 1'b1;
                            fault_cause <= FAULT_TIMEOUT;
                            fault_pc    <= op_pc;
                        end
                        state <= S_DRAIN;
                    end else begin
                        if (flush) begin
                            squash <= 1'b1;
                        end
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end

                S_DRAIN: begin
                    // Late pulses from the timed-out op are swallowed here.
                    if (!switch_busy && !switch_complete && !switch_fault) begin
                        state <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ctmm_church_dispatch.sv
// Self-checking bench for ctmm_church_dispatch: directed scenarios plus a
// randomized run checked against a word-level reference model.
module tb_ctmm_church_dispatch;
    import ctmm_pkg::*;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_word;
    logic [63:0] inst_pc;
    logic        flush;
    logic        switch_start;
    logic [2:0]  sw_cr_src;
    logic [2:0]  sw_target;
    logic [9:0]  sw_index;
    logic        switch_busy;
    logic        switch_complete;
    logic        switch_fault;
    fault_type_t sw_fault_type;
    logic        retire_valid;
    logic [63:0] retire_pc;
    logic        fault_valid;
    fault_type_t fault_cause;
    logic [63:0] fault_pc;
    logic        dispatch_idle;

    always #5 clk = ~clk;

    ctmm_church_dispatch #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_word       (inst_word),
        .inst_pc         (inst_pc),
        .flush           (flush),
        .switch_start    (switch_start),
        .sw_cr_src       (sw_cr_src),
        .sw_target       (sw_target),
        .sw_index        (sw_index),
        .switch_busy     (switch_busy),
        .switch_complete (switch_complete),
        .switch_fault    (switch_fault),
        .sw_fault_type   (sw_fault_type),
        .retire_valid    (retire_valid),
        .retire_pc       (retire_pc),
        .fault_valid     (fault_valid),
        .fault_cause     (fault_cause),
        .fault_pc        (fault_pc),
        .dispatch_idle   (dispatch_idle)
    );

    // Stub response: pulse complete (busy held) or fault (busy dropped) after delay cycles.
    typedef struct {
        bit          is_fault;
        int          delay;
        fault_type_t ftype;
    } resp_t;

    typedef struct {
        bit          is_fault;
        fault_type_t cause;
        logic [63:0] pc;
        int          cyc;
    } rep_t;

    typedef struct {
        logic [2:0] src;
        logic [2:0] tgt;
        logic [9:0] idx;
        int         cyc;
    } start_t;

    resp_t  stub_q[$];
    rep_t   rep_q[$];
    start_t start_q[$];
    int     cyc = 0;
    bit     stub_active = 1'b0;
    int     tests_run = 0;
    int     tests_failed = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observe start pulses and reports away from the active edge.
    always @(negedge clk) begin
        if (switch_start === 1'b1)
            start_q.push_back('{src: sw_cr_src, tgt: sw_target, idx: sw_index, cyc: cyc});
        if (retire_valid === 1'b1)
            rep_q.push_back('{is_fault: 1'b0, cause: FAULT_NONE, pc: retire_pc, cyc: cyc});
        if (fault_valid === 1'b1)
            rep_q.push_back('{is_fault: 1'b1, cause: fault_cause, pc: fault_pc, cyc: cyc});
    end

    // SWITCH unit stub, consuming one scripted response per start pulse.
    initial begin
        resp_t r;
        switch_busy     = 1'b0;
        switch_complete = 1'b0;
        switch_fault    = 1'b0;
        sw_fault_type   = FAULT_NONE;
        forever begin
            @(negedge clk);
            if (switch_start === 1'b1) begin
                stub_active = 1'b1;
                r = (stub_q.size() > 0) ? stub_q.pop_front()
                                        : '{is_fault: 1'b0, delay: 2, ftype: FAULT_NONE};
                switch_busy = 1'b1;
                repeat (r.delay) @(negedge clk);
                if (r.is_fault) begin
                    switch_busy   = 1'b0;
                    switch_fault  = 1'b1;
                    sw_fault_type = r.ftype;
                end else begin
                    switch_complete = 1'b1;
                end
                @(negedge clk);
                switch_busy     = 1'b0;
                switch_complete = 1'b0;
                switch_fault    = 1'b0;
                sw_fault_type   = FAULT_NONE;
                stub_active     = 1'b0;
            end
        end
    end

    function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] src,
                                       input logic [2:0] tgt, input logic [9:0] idx,
                                       input logic [10:0] rsvd);
        return {opc, src, tgt, idx, rsvd};
    endfunction

    // Offer one word and hold it until accepted; called and returns at a negedge.
    task automatic push_word(input logic [31:0] w, input logic [63:0] pc);
        int budget = 200;
        inst_valid = 1'b1;
        inst_word  = w;
        inst_pc    = pc;
        while (inst_ready !== 1'b1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        tests_run++;
        if (budget == 0) begin
            tests_failed++;
            $display("FAIL push_accept: inst_ready stayed %b for 200 cycles, required 1", inst_ready);
        end
        @(negedge clk);
        inst_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        @(negedge clk);
        while (!(dispatch_idle === 1'b1 && !stub_active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        tests_run++;
        if (n >= 300) begin
            tests_failed++;
            $display("FAIL %s_idle: dispatch_idle=%b after %0d cycles, required 1", name, dispatch_idle, n);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic clear_obs();
        rep_q.delete();
        start_q.delete();
        stub_q.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        inst_word  = '0;
        inst_pc    = '0;
        flush      = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (inst_ready !== 1'b1 || dispatch_idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_ready_idle: got ready=%b idle=%b, required 1/1", inst_ready, dispatch_idle);
        end
        tests_run++;
        if ({switch_start, retire_valid, fault_valid} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_pulses: got start/retire/fault=%b, required 000",
                     {switch_start, retire_valid, fault_valid});
        end
        tests_run++;
        if ({sw_cr_src, sw_target, sw_index} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_fields: got %h, required 0000", {sw_cr_src, sw_target, sw_index});
        end
        tests_run++;
        if (retire_pc !== 64'h0 || fault_pc !== 64'h0 || fault_cause !== FAULT_NONE) begin
            tests_failed++;
            $display("FAIL reset_report_regs: got retire_pc=%h fault_pc=%h cause=%0d, required 0/0/NONE",
                     retire_pc, fault_pc, fault_cause);
        end
    endtask

    task automatic test_switch_basic();
        logic [63:0] pc = {$urandom, $urandom};
        clear_obs();
        stub_q.push_back('{is_fault: 1'b0, delay: 5, ftype: FAULT_NONE});
        push_word(mk(OPC_SWITCH, 3'd3, 3'd7, 10'h155, 11'h0), pc);
        wait_idle("basic");
        tests_run++;
        if (start_q.size() != 1) begin
            tests_failed++;
            $display("FAIL basic_start_count: got %0d, required 1", start_q.size());
        end else if (start_q[0].src !== 3'd3 || start_q[0].tgt !== 3'd7 || start_q[0].idx !== 10'h155) begin
            tests_failed++;
            $display("FAIL basic_fields: got src=%0d tgt=%0d idx=%h, required 3/7/155",
                     start_q[0].src, start_q[0].tgt, start_q[0].idx);
        end
        tests_run++;
        if (rep_q.size() != 1 || rep_q[0].is_fault !== 1'b0 || rep_q[0].pc !== pc) begin
            tests_failed++;
            $display("FAIL basic_retire: got %0d reports (first fault=%b pc=%h), required one retire pc=%h",
                     rep_q.size(), rep_q.size() > 0 ? rep_q[0].is_fault : 1'b0,
                     rep_q.size() > 0 ? rep_q[0].pc : 64'h0, pc);
        end else if (start_q.size() == 1) begin
            tests_run++;
            if (rep_q[0].cyc - start_q[0].cyc != 6) begin
                tests_failed++;
                $display("FAIL basic_latency: retire %0d cycles after start, required 6",
                         rep_q[0].cyc - start_q[0].cyc);
            end
        end
    endtask

    task automatic test_change();
        logic [63:0] pc  = {$urandom, $urandom};
        logic [9:0]  idx = 10'($urandom);
        clear_obs();
        stub_q.push_back('{is_fault: 1'b0, delay: 2, ftype: FAULT_NONE});
        push_word(mk(OPC_CHANGE, 3'd5, 3'd5, idx, 11'h0), pc);
        wait_idle("change");
        tests_run++;
        if (start_q.size() != 1 || start_q[0].tgt !== 3'd0 || start_q[0].src !== 3'd5 ||
            start_q[0].idx !== idx) begin
            tests_failed++;
            $display("FAIL change_fields: got %0d starts (tgt=%0d), required 1 with src=5 tgt=0 idx=%h",
                     start_q.size(), start_q.size() > 0 ? start_q[0].tgt : 3'd0, idx);
        end
        tests_run++;
        if (rep_q.size() != 1 || rep_q[0].is_fault !== 1'b0 || rep_q[0].pc !== pc) begin
            tests_failed++;
            $display("FAIL change_retire: got %0d reports, required one retire pc=%h", rep_q.size(), pc);
        end
    endtask

    task automatic test_illegal();
        logic [63:0] pc_a = {$urandom, $urandom};
        logic [63:0] pc_b = {$urandom, $urandom};
        clear_obs();
        push_word(mk(OPC_SWITCH, 3'd1, 3'd2, 10'h3, 11'h001), pc_a);
        push_word(mk(5'h1F, 3'd0, 3'd0, 10'h0, 11'h0), pc_b);
        wait_idle("illegal");
        tests_run++;
        if (start_q.size() != 0) begin
            tests_failed++;
            $display("FAIL illegal_no_start: got %0d starts, required 0", start_q.size());
        end
        tests_run++;
        if (rep_q.size() != 2) begin
            tests_failed++;
            $display("FAIL illegal_count: got %0d reports, required 2", rep_q.size());
        end else if (rep_q[0].cause !== FAULT_ILLEGAL || rep_q[0].pc !== pc_a ||
                     rep_q[1].cause !== FAULT_ILLEGAL || rep_q[1].pc !== pc_b ||
                     !rep_q[0].is_fault || !rep_q[1].is_fault) begin
            tests_failed++;
            $display("FAIL illegal_reports: got cause %0d/%0d pc %h/%h, required ILLEGAL x2 pc %h/%h",
                     rep_q[0].cause, rep_q[1].cause, rep_q[0].pc, rep_q[1].pc, pc_a, pc_b);
        end
    endtask

    task automatic test_fault_perm();
        logic [63:0] pc_a = {$urandom, $urandom};
        logic [63:0] pc_b = {$urandom, $urandom};
        clear_obs();
        stub_q.push_back('{is_fault: 1'b1, delay: 3, ftype: FAULT_PERM});
        stub_q.push_back('{is_fault: 1'b0, delay: 2, ftype: FAULT_NONE});
        push_word(mk(OPC_SWITCH, 3'd2, 3'd1, 10'h10, 11'h0), pc_a);
        push_word(mk(OPC_SWITCH, 3'd4, 3'd6, 10'h20, 11'h0), pc_b);
        wait_idle("perm");
        tests_run++;
        if (rep_q.size() != 2) begin
            tests_failed++;
            $display("FAIL perm_count: got %0d reports, required 2", rep_q.size());
        end else begin
            tests_run++;
            if (!rep_q[0].is_fault || rep_q[0].cause !== FAULT_PERM || rep_q[0].pc !== pc_a) begin
                tests_failed++;
                $display("FAIL perm_fault: got fault=%b cause=%0d pc=%h, required 1/PERM/%h",
                         rep_q[0].is_fault, rep_q[0].cause, rep_q[0].pc, pc_a);
            end
            tests_run++;
            if (rep_q[1].is_fault || rep_q[1].pc !== pc_b) begin
                tests_failed++;
                $display("FAIL perm_next_retire: got fault=%b pc=%h, required retire pc=%h",
                         rep_q[1].is_fault, rep_q[1].pc, pc_b);
            end
        end
    endtask

    task automatic test_timeout();
        logic [63:0] pc = {$urandom, $urandom};
        clear_obs();
        stub_q.push_back('{is_fault: 1'b0, delay: 12, ftype: FAULT_NONE});
        push_word(mk(OPC_SWITCH, 3'd7, 3'd0, 10'h3FF, 11'h0), pc);
        wait_idle("timeout");
        tests_run++;
        if (rep_q.size() != 1 || !rep_q[0].is_fault || rep_q[0].cause !== FAULT_TIMEOUT ||
            rep_q[0].pc !== pc) begin
            tests_failed++;
            $display("FAIL timeout_report: got %0d reports (cause=%0d), required one TIMEOUT pc=%h",
                     rep_q.size(), rep_q.size() > 0 ? rep_q[0].cause : FAULT_NONE, pc);
        end else if (start_q.size() == 1) begin
            tests_run++;
            if (rep_q[0].cyc - start_q[0].cyc != TMO) begin
                tests_failed++;
                $display("FAIL timeout_latency: fault %0d cycles after entering WAIT, required %0d",
                         rep_q[0].cyc - start_q[0].cyc, TMO);
            end
        end
    endtask

    task automatic test_back_to_back_flush();
        logic [63:0] pc_d = {$urandom, $urandom};
        clear_obs();
        stub_q.push_back('{is_fault: 1'b0, delay: 10, ftype: FAULT_NONE});
        stub_q.push_back('{is_fault: 1'b0, delay: 2, ftype: FAULT_NONE});
        push_word(mk(OPC_SWITCH, 3'd1, 3'd1, 10'h1, 11'h0), 64'hA0);
        push_word(mk(OPC_SWITCH, 3'd2, 3'd2, 10'h2, 11'h0), 64'hB0);
        push_word(mk(OPC_SWITCH, 3'd3, 3'd3, 10'h3, 11'h0), 64'hC0);
        tests_run++;
        if (inst_ready !== 1'b0 || dispatch_idle !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_full: got ready=%b idle=%b, required 0/0", inst_ready, dispatch_idle);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        tests_run++;
        if (inst_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_empty: got ready=%b, required 1", inst_ready);
        end
        wait_idle("flush");
        tests_run++;
        if (rep_q.size() != 0 || start_q.size() != 1 || dispatch_idle !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_squash: got %0d reports %0d starts idle=%b, required 0/1/1",
                     rep_q.size(), start_q.size(), dispatch_idle);
        end
        push_word(mk(OPC_CHANGE, 3'd6, 3'd0, 10'h44, 11'h0), pc_d);
        wait_idle("post_flush");
        tests_run++;
        if (rep_q.size() != 1 || rep_q[0].is_fault || rep_q[0].pc !== pc_d) begin
            tests_failed++;
            $display("FAIL post_flush_retire: got %0d reports, required one retire pc=%h",
                     rep_q.size(), pc_d);
        end
    endtask

    task automatic test_random();
        rep_t   exp_rep[$];
        start_t exp_st[$];
        int     min_gap = 1000;
        clear_obs();
        for (int n = 0; n < 30; n++) begin
            int          sel = $urandom_range(0, 9);
            logic [4:0]  opc = (sel < 4) ? OPC_SWITCH : (sel < 8) ? OPC_CHANGE : 5'($urandom);
            logic [2:0]  src = 3'($urandom);
            logic [2:0]  tgt = 3'($urandom);
            logic [9:0]  idx = 10'($urandom);
            logic [10:0] rsvd = ($urandom_range(0, 5) == 0) ? 11'(1 << $urandom_range(0, 10)) : 11'h0;
            logic [63:0] pc = {$urandom, $urandom};
            if (!((opc == OPC_SWITCH || opc == OPC_CHANGE) && rsvd == 11'h0)) begin
                exp_rep.push_back('{is_fault: 1'b1, cause: FAULT_ILLEGAL, pc: pc, cyc: 0});
            end else begin
                int kind = $urandom_range(0, 5);
                exp_st.push_back('{src: src, tgt: (opc == OPC_CHANGE) ? 3'd0 : tgt, idx: idx, cyc: 0});
                if (kind < 3) begin
                    stub_q.push_back('{is_fault: 1'b0, delay: $urandom_range(1, 6), ftype: FAULT_NONE});
                    exp_rep.push_back('{is_fault: 1'b0, cause: FAULT_NONE, pc: pc, cyc: 0});
                end else if (kind < 5) begin
                    fault_type_t ft = (kind == 3) ? FAULT_PERM : ($urandom_range(0, 1) ? FAULT_BOUNDS : FAULT_TYPE);
                    stub_q.push_back('{is_fault: 1'b1, delay: $urandom_range(1, 6), ftype: ft});
                    exp_rep.push_back('{is_fault: 1'b1, cause: ft, pc: pc, cyc: 0});
                end else begin
                    stub_q.push_back('{is_fault: 1'b0, delay: $urandom_range(TMO + 1, TMO + 4), ftype: FAULT_NONE});
                    exp_rep.push_back('{is_fault: 1'b1, cause: FAULT_TIMEOUT, pc: pc, cyc: 0});
                end
            end
            push_word(mk(opc, src, tgt, idx, rsvd), pc);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle("random");
        tests_run++;
        if (rep_q.size() != exp_rep.size() || start_q.size() != exp_st.size()) begin
            tests_failed++;
            $display("FAIL random_counts: got %0d reports %0d starts, required %0d/%0d",
                     rep_q.size(), start_q.size(), exp_rep.size(), exp_st.size());
        end else begin
            for (int i = 0; i < exp_rep.size(); i++) begin
                tests_run++;
                if (rep_q[i].is_fault !== exp_rep[i].is_fault || rep_q[i].pc !== exp_rep[i].pc ||
                    (exp_rep[i].is_fault && rep_q[i].cause !== exp_rep[i].cause)) begin
                    tests_failed++;
                    $display("FAIL random_report[%0d]: got fault=%b cause=%0d pc=%h, required fault=%b cause=%0d pc=%h",
                             i, rep_q[i].is_fault, rep_q[i].cause, rep_q[i].pc,
                             exp_rep[i].is_fault, exp_rep[i].cause, exp_rep[i].pc);
                end
            end
            for (int i = 0; i < exp_st.size(); i++) begin
                tests_run++;
                if (start_q[i].src !== exp_st[i].src || start_q[i].tgt !== exp_st[i].tgt ||
                    start_q[i].idx !== exp_st[i].idx) begin
                    tests_failed++;
                    $display("FAIL random_start[%0d]: got %0d/%0d/%h, required %0d/%0d/%h", i,
                             start_q[i].src, start_q[i].tgt, start_q[i].idx,
                             exp_st[i].src, exp_st[i].tgt, exp_st[i].idx);
                end
                if (i > 0 && start_q[i].cyc - start_q[i-1].cyc < min_gap)
                    min_gap = start_q[i].cyc - start_q[i-1].cyc;
            end
            if (exp_st.size() > 1) begin
                tests_run++;
                if (min_gap < 4) begin
                    tests_failed++;
                    $display("FAIL random_start_spacing: got min gap %0d, required >= 4", min_gap);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_switch_basic();
        test_change();
        test_illegal();
        test_fault_perm();
        test_timeout();
        test_back_to_back_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ctmm_church_dispatch.md
# ctmm_church_dispatch

Front-end issue stage for the SWITCH/CHANGE Church-Instructions. It accepts 32-bit instruction words from fetch through a 2-entry queue and decodes SWITCH and its CHANGE alias into source register, target and C-List index. It issues one operation at a time to the SWITCH execution unit and guards the wait with a timeout. Each operation ends in exactly one retire or fault report.

## Interface
- TIMEOUT_CYCLES, 1024: max cycles in WAIT before a timeout fault; must be ≥ 2 and fit in 16 bits.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- inst_valid  in  1  fetch offers a word.
- inst_ready  out  1  queue can accept a word.
- inst_word  in  32  instruction.
- inst_pc  in  64  address of the word.
- flush  in  1  discard queued words and squash the in-flight operation.
- switch_start  out  1  one-cycle start pulse to the SWITCH unit.
- sw_cr_src  out  3  source CR0–CR7.
- sw_target  out  3  target, selecting CR8+target.
- sw_index  out  10  C-List index.
- switch_busy  in  1  SWITCH unit busy.
- switch_complete  in  1  success pulse.
- switch_fault  in  1  fault pulse.
- sw_fault_type  in  fault_type_t  fault cause from the SWITCH unit.
- retire_valid  out  1  one-cycle pulse: operation succeeded.
- retire_pc  out  64  PC of the retired operation.
- fault_valid  out  1  one-cycle pulse: operation faulted.
- fault_cause  out  fault_type_t  reported fault cause.
- fault_pc  out  64  PC of the faulting word.
- dispatch_idle  out  1  queue empty and FSM in IDLE.

## Operation
- Decode:
  - inst_word[31:27] is the opcode: SWITCH=5'h0C, CHANGE=5'h0D.
  - [26:24] is cr_src; [23:21] is target; [20:11] is index.
  - [10:0] is reserved and must be zero.
  - For CHANGE, target is forced to 0.
- Queue:
  - 2 entries, each holding {word, pc}.
  - A push occurs on inst_valid && inst_ready.
  - inst_ready = !full.
  - A push and a pop in the same cycle are legal and leave the count unchanged.
  - A pointer wraps from 1 to 0.
- FSM states:
  - IDLE:
    - If the queue is non-empty, pop the head.
    - If the opcode is illegal or any reserved bit is nonzero, emit a fault with FAULT_ILLEGAL and return to IDLE. The SWITCH unit is not started.
    - Otherwise, latch the fields and go to ISSUE.
  - ISSUE:
    - Assert switch_start for exactly one cycle. The cycle must not be one where switch_busy=1 (see WAIT).
    - Clear the timeout counter and go to WAIT.
  - WAIT:
    - On switch_complete: retire and go to IDLE.
    - On switch_fault: fault with sw_fault_type and go to IDLE.
    - If both are asserted in the same cycle, fault wins.
    - When the counter reaches TIMEOUT_CYCLES−1 with no event: fault with FAULT_TIMEOUT and go to DRAIN.
    - switch_busy falling alone is not a completion, because the unit reports faults while idle.
  - DRAIN:
    - Wait for switch_busy=0 and no pending pulse, then go to IDLE.
    - A late complete or fault arriving here is discarded.
- sw_cr_src, sw_target and sw_index are registered. They hold stable from ISSUE until the FSM leaves WAIT.
- Flush:
  - Empties the queue in the same cycle; a simultaneous push is dropped.
  - If the FSM is in ISSUE or WAIT, set the squash flag. The operation runs to completion, and its retire or fault is suppressed.
  - The squash flag clears on entry to IDLE.
  - A timeout fault raised while squashed is also suppressed.

## Timing
- Reset values:
  - State IDLE, queue empty, inst_ready=1.
  - switch_start, retire_valid and fault_valid are 0.
  - All field, PC and cause outputs are 0; fault_cause=FAULT_NONE.
  - dispatch_idle=1.
- inst_ready is combinational from the count only, with no dependence on inst_valid.
- Latency:
  - Push at cycle t allows IDLE to pop at t+1 and ISSUE to run at t+2.
  - Retire and fault outputs are registered: one cycle after the terminating event is sampled.
- Decode faults are reported one cycle after the pop.
- Back-to-back operations: the minimum spacing between switch_start pulses is 4 cycles.
- rst_n asserted mid-operation forces reset values immediately. Queue contents are lost.

## Structure
- ctmm_pkg adds:
  - enum members FAULT_ILLEGAL and FAULT_TIMEOUT in fault_type_t;
  - localparams OPC_SWITCH and OPC_CHANGE;
  - a church_inst_t packed struct with fields opcode, cr_src, target, index and rsvd.
- One sub-module, ctmm_inst_queue: a 2-entry synchronous FIFO with push, pop, flush, full and empty. The dispatch FSM is written inline.

## Test plan
- SWITCH with cr_src=3, target=7, index=0x155; stub asserts complete 5 cycles after start → one switch_start pulse, then retire_valid with retire_pc equal to the pushed PC; no fault.
- CHANGE word with target bits=5 → sw_target=0 at issue.
- Reserved bit 0 set, or opcode 5'h1F → fault_valid with FAULT_ILLEGAL; switch_start never asserted.
- Stub pulses switch_fault with FAULT_PERM while switch_busy=0 → fault_valid, fault_cause=FAULT_PERM, correct fault_pc; next queued word then issues.
- Stub never responds, TIMEOUT_CYCLES=8 → FAULT_TIMEOUT exactly 8 cycles after entering WAIT; a later complete is discarded.
- Three words pushed back-to-back → inst_ready drops after two; flush during WAIT → queue empty, in-flight complete produces no retire_valid, dispatch_idle=1 afterwards.
